lane_serializer: RTL and testbench
==================================

LANE_SERIALIZER -- requirements
Module: lane_serializer

Interface
REQ-001 SHALL have parameter N_LANES, default 8, giving the number of elements in the input unpacked array; legal range 2..64.
REQ-002 SHALL have parameter IDX_W, default $clog2(N_LANES), giving the width of the element index output.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_a, input, unpacked logic [N_LANES], parallel word from the upstream array-broadcast stage; element 0 is sent first.
REQ-006 SHALL have port i_valid, input, 1, meaning i_a holds a word to capture.
REQ-007 SHALL have port o_ready, output, 1, meaning the block accepts i_a this cycle.
REQ-008 SHALL have port o_data, output, 1, the current serial element.
REQ-009 SHALL have port o_valid, output, 1, meaning o_data is valid.
REQ-010 SHALL have port i_ready, input, 1, downstream acceptance of o_data.
REQ-011 SHALL have port o_idx, output, IDX_W, index of the element on o_data.
REQ-012 SHALL have port o_last, output, 1, high when o_idx == N_LANES-1 and o_valid is high.
REQ-013 SHALL have port o_ones, output, IDX_W+1, count of ones in the most recently captured word.

Function
REQ-014 SHALL implement two states: IDLE and SHIFT.
REQ-015 In IDLE: o_ready=1, o_valid=0; on i_valid, capture all N_LANES elements of i_a into an internal buffer, set index 0, load o_ones with the popcount of i_a, and go to SHIFT.
REQ-016 In SHIFT: o_valid=1, o_data=buffer[index], o_idx=index.
REQ-017 In SHIFT with i_ready=1 and index < N_LANES-1: increment the index by one and stay in SHIFT.
REQ-018 In SHIFT with i_ready=1 and index == N_LANES-1 (the final handshake): if i_valid=0, go to IDLE; if i_valid=1, capture the new word in that cycle, reset the index to 0, update o_ones, and stay in SHIFT.
REQ-019 o_ready is 1 in IDLE, 1 in SHIFT when o_last && i_ready, and 0 otherwise; this combinational path from i_ready is intentional.
REQ-020 In SHIFT with i_ready=0: hold the index, buffer, o_data, o_idx and o_valid stable.
REQ-021 Changes on i_a while not capturing SHALL NOT affect the buffer or o_ones.
REQ-022 The index SHALL never exceed N_LANES-1 and SHALL return to 0 only on a capture.
REQ-023 Latency: the first element appears on o_data in the cycle after capture. Throughput is one word per N_LANES cycles with continuous i_valid and i_ready, with no idle bubble between words.
REQ-024 o_ones SHALL hold its value until the next capture, including across a return to IDLE.

Reset
REQ-025 While i_rst=1 (asynchronous assertion): state=IDLE, index=0, buffer all 0, o_ones=0, o_valid=0, o_data=0, o_idx=0, o_last=0, o_ready=1.
REQ-026 Reset asserted mid-SHIFT SHALL abort the word immediately with no further o_valid. The first rising edge after deassertion SHALL behave as IDLE.

Verification
REQ-027 Single word, N_LANES=8: i_a={1,0,1,1,0,0,0,1} (element 0 first), i_valid one cycle, i_ready=1 -> o_data sequence 1,0,1,1,0,0,0,1 on the 8 following cycles, o_idx 0..7, o_last only at idx 7, o_ones=4, then IDLE with o_ready=1.
REQ-028 Backpressure: i_ready=0 for 3 cycles at idx 2 -> o_data, o_idx=2 and o_valid held for those cycles, then the sequence resumes at idx 3 with no element lost or duplicated.
REQ-029 Back-to-back: i_valid held high with two words, all-ones then all-zeros -> o_ready pulses at idx 7 of word 1, 16 consecutive o_valid cycles, second o_ones=0.
REQ-030 Input stability: i_a toggled every cycle during SHIFT -> the serialized output matches only the captured word.
REQ-031 Reset mid-operation: assert i_rst asynchronously at idx 4 -> all outputs take their REQ-025 values before the next clock edge; a new word afterwards starts at idx 0.

Source files
------------

// File: rtl/lane_serializer.sv
// Serializes an N_LANES-element word one element per accepted cycle, element 0 first.
// A new word may be captured on the final handshake of the current one, so back-to-back words have no bubble.
module lane_serializer #(
    parameter int N_LANES = 8,
    parameter int IDX_W   = $clog2(N_LANES)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a [N_LANES],
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last,
    output logic [IDX_W:0]   o_ones
);

    typedef enum logic {IDLE, SHIFT} state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   ones_q, ones_d;
    logic             buf_q [N_LANES];
    logic             capture;
    logic             at_end;

    always_comb begin
        ones_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            ones_d = ones_d + {{IDX_W{1'b0}}, i_a[i]};
        end
    end

    assign at_end = (idx_q == LAST_IDX);

    // o_ready depends combinationally on i_ready so the next word can be taken on the final handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_data  = 1'b0;
        o_last  = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                o_valid = 1'b1;
                o_data  = buf_q[idx_q];
                o_last  = at_end;
                o_ready = at_end && i_ready;
                if (i_ready) begin
                    if (!at_end) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (i_valid) begin
                        capture = 1'b1;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ones_q  <= '0;
            buf_q   <= '{default: 1'b0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                buf_q  <= i_a;
                ones_q <= ones_d;
            end
        end
    end

    assign o_idx  = idx_q;
    assign o_ones = ones_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Scoreboard bench for lane_serializer: table of words plus hand-written backpressure,
// back-to-back and mid-word reset sequences.
module tb_lane_serializer;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] word;
        int           ones;
        bit           randReady;
    } vec_t;

    typedef struct {
        logic data;
        int   idx;
        logic last;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       aIn [N];
    logic       validIn;
    logic       readyOut;
    logic       dataOut;
    logic       validOut;
    logic       readyIn;
    logic [2:0] idxOut;
    logic       lastOut;
    logic [3:0] onesOut;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[8];

    lane_serializer #(.N_LANES(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_a     (aIn),
        .i_valid (validIn),
        .o_ready (readyOut),
        .o_data  (dataOut),
        .o_valid (validOut),
        .i_ready (readyIn),
        .o_idx   (idxOut),
        .o_last  (lastOut),
        .o_ones  (onesOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic driveNoise();
        for (int j = 0; j < N; j++) aIn[j] = 1'($urandom_range(0, 1));
    endtask

    task automatic pushWord(input logic [N-1:0] word);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = word[k];
            e.idx  = k;
            e.last = (k == N - 1);
            sb.push_back(e);
        end
    endtask

    // Captures one word from IDLE; returns at the negedge showing element 0.
    task automatic applyStimulus(input logic [N-1:0] word, input int ones);
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) aIn[j] = word[j];
        validIn = 1'b1;
        readyIn = 1'b1;
        pushWord(word);
        @(posedge clk); #1;
        validIn = 1'b0;
        driveNoise();
        @(negedge clk);
        checkOutput("ones_after_capture", onesOut, ones);
        checkOutput("valid_after_capture", validOut, 1);
    endtask

    task automatic drainWord(input bit randReady);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            driveNoise();
            readyIn = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout_left", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic checkIdle(input int ones);
        @(negedge clk);
        checkOutput("idle_valid", validOut, 0);
        checkOutput("idle_ready", readyOut, 1);
        checkOutput("idle_ones_held", onesOut, ones);
        readyIn = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, readyOut, 1);
        checkOutput({tag, "_valid"}, validOut, 0);
        checkOutput({tag, "_data"}, dataOut, 0);
        checkOutput({tag, "_idx"}, idxOut, 0);
        checkOutput({tag, "_last"}, lastOut, 0);
        checkOutput({tag, "_ones"}, onesOut, 0);
    endtask

    // Every accepted element is compared against the front of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && validOut && readyIn) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("serial_data", dataOut, e.data);
                checkOutput("serial_idx", idxOut, e.idx);
                checkOutput("serial_last", lastOut, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int validCnt, gaps, firstReadyAt, n;

        rst     = 1'b1;
        validIn = 1'b0;
        readyIn = 1'b1;
        for (int j = 0; j < N; j++) aIn[j] = 1'b0;
        #3;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        vecs[0] = '{word: 8'h8D, ones: 4, randReady: 1'b0};
        vecs[1] = '{word: 8'hFF, ones: 8, randReady: 1'b0};
        vecs[2] = '{word: 8'h00, ones: 0, randReady: 1'b1};
        vecs[3] = '{word: 8'hA5, ones: 4, randReady: 1'b1};
        vecs[4] = '{word: 8'h01, ones: 1, randReady: 1'b0};
        vecs[5] = '{word: 8'h80, ones: 1, randReady: 1'b1};
        vecs[6] = '{word: 8'h3C, ones: 4, randReady: 1'b1};
        vecs[7] = '{word: 8'h6E, ones: 5, randReady: 1'b1};

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k].word, vecs[k].ones);
            drainWord(vecs[k].randReady);
            checkIdle(vecs[k].ones);
        end

        // Backpressure: stall three cycles while element 2 is presented.
        applyStimulus(8'h8D, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        readyIn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_idx", idxOut, 2);
            checkOutput("stall_data", dataOut, 1);
            checkOutput("stall_valid", validOut, 1);
            @(posedge clk); #1;
            driveNoise();
        end
        readyIn = 1'b1;
        drainWord(1'b0);
        checkIdle(4);

        // Back-to-back: all-ones then all-zeros with i_valid held high.
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) aIn[j] = 1'b1;
        validIn = 1'b1;
        readyIn = 1'b1;
        pushWord(8'hFF);
        pushWord(8'h00);
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) aIn[j] = 1'b0;
        validCnt     = 0;
        gaps         = 0;
        firstReadyAt = -1;
        n            = 0;
        while (sb.size() != 0 && n < 64) begin
            @(negedge clk);
            if (validOut) validCnt++;
            else gaps++;
            if (n == 0) checkOutput("b2b_first_ones", onesOut, 8);
            if (readyOut && firstReadyAt < 0) firstReadyAt = validCnt;
            @(posedge clk); #1;
            if (firstReadyAt >= 0) validIn = 1'b0;
            n++;
        end
        validIn = 1'b0;
        checkOutput("b2b_drained_left", sb.size(), 0);
        sb.delete();
        checkOutput("b2b_first_ready_at", firstReadyAt, 8);
        checkOutput("b2b_valid_cycles", validCnt, 16);
        checkOutput("b2b_gaps", gaps, 0);
        checkIdle(0);

        // Reset asserted asynchronously while element 4 is presented.
        applyStimulus(8'hA5, 4);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkResetOutputs("midreset");
        sb.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postreset_valid", validOut, 0);
        checkOutput("postreset_ready", readyOut, 1);
        applyStimulus(8'h3C, 4);
        drainWord(1'b1);
        checkIdle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
